bcd_counter_n: RTL and testbench

Parametrised multi-digit BCD up/down counter, the successor to the single-purpose BCD counter in our TinyTapeout user module. It provides N cascaded decimal digits, synchronous load, direction control, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It also includes a built-in digit scanner that drives a multiplexed 7-segment display stage. It sits between the `ui_in` control decode and the `uo_out`/`uio_out` display drivers.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit.sv | 30 +++
 rtl/bcd_counter_n.sv | 106 ++++++++++
 tb/tb_bcd_counter_n.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and the load-value clamp helper
// used by the multi-digit counter and its per-digit step logic.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    // Nibbles 10..15 are not legal BCD; they load as 9.
    function automatic bcd_t bcd_clamp(input bcd_t value);
        return (value > BCD_MAX) ? BCD_MAX : value;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the counter: computes the stepped value and the
// carry/borrow into the next digit. Purely combinational.
module bcd_digit
    import bcd_pkg::*;
(
    input  bcd_t digit,
    input  logic up,
    input  logic step_in,
    output bcd_t next_digit,
    output logic step_out
);

    logic at_edge;

    // A digit at 9 (counting up) or 0 (counting down) rolls over and passes the step on.
    assign at_edge  = up ? (digit == BCD_MAX) : (digit == BCD_MIN);
    assign step_out = step_in & at_edge;

    always_comb begin
        next_digit = digit;
        if (step_in) begin
            if (at_edge) begin
                next_digit = up ? BCD_MIN : BCD_MAX;
            end else begin
                next_digit = up ? (digit + 4'd1) : (digit - 4'd1);
            end
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with load, wrap/saturate, terminal-count pulse,
// sticky overflow and a free-running multiplexed-display digit scanner.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int WRAP     = 1,
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_val,
    input  logic                  clr_ovf,
    output logic [4*N_DIGITS-1:0] count,
    output logic                  tc,
    output logic                  ovf,
    output logic [3:0]            seg_digit,
    output logic [N_DIGITS-1:0]   seg_sel
);

    localparam int W     = 4 * N_DIGITS;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [W-1:0]        count_reg;
    logic [W-1:0]        count_next;
    logic [W-1:0]        load_clamped;
    logic [N_DIGITS:0]   step_chain;
    logic                tc_reg;
    logic                ovf_reg;
    logic [DIV_W-1:0]    div_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                boundary;
    logic                ovf_set;

    // Digit 0 always receives the step; a carry out of the top digit marks a boundary step.
    assign step_chain[0] = 1'b1;
    assign boundary      = step_chain[N_DIGITS];
    assign ovf_set       = en & ~load & boundary;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .digit      (count_reg[gi*4 +: 4]),
                .up         (up),
                .step_in    (step_chain[gi]),
                .next_digit (count_next[gi*4 +: 4]),
                .step_out   (step_chain[gi+1])
            );

            assign load_clamped[gi*4 +: 4] = bcd_clamp(load_val[gi*4 +: 4]);
            assign seg_sel[gi]             = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            ovf_reg <= ovf_set | (ovf_reg & ~clr_ovf);
            if (load) begin
                count_reg <= load_clamped;
                tc_reg    <= 1'b0;
            end else if (en) begin
                // Saturate mode holds the value at the boundary but still pulses tc.
                if (!(boundary && (WRAP == 0))) begin
                    count_reg <= count_next;
                end
                tc_reg <= boundary;
            end else begin
                tc_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= '0;
            idx_reg <= '0;
        end else if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
            div_reg <= '0;
            idx_reg <= (idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : (idx_reg + IDX_W'(1));
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    always_comb begin
        seg_digit = 4'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                seg_digit = count_reg[i*4 +: 4];
            end
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench: a decimal-integer reference model predicts each cycle's outputs
// for a wrapping and a saturating 3-digit counter; a monitor pops and compares.
module tb_bcd_counter_n;

    localparam int N        = 3;
    localparam int SCAN_DIV = 4;
    localparam int MAXV     = 999;

    logic        clk;
    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic [11:0] load_val;
    logic        clr_ovf;

    logic [11:0] count_w, count_s;
    logic        tc_w, tc_s, ovf_w, ovf_s;
    logic [3:0]  seg_digit_w, seg_digit_s;
    logic [2:0]  seg_sel_w, seg_sel_s;

    bcd_counter_n #(.N_DIGITS(N), .WRAP(1), .SCAN_DIV(SCAN_DIV)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(count_w), .tc(tc_w), .ovf(ovf_w),
        .seg_digit(seg_digit_w), .seg_sel(seg_sel_w)
    );

    bcd_counter_n #(.N_DIGITS(N), .WRAP(0), .SCAN_DIV(SCAN_DIV)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(count_s), .tc(tc_s), .ovf(ovf_s),
        .seg_digit(seg_digit_s), .seg_sel(seg_sel_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int   cw;
        logic tcw;
        logic ovw;
        int   cs;
        logic tcs;
        logic ovs;
        int   idx;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    // Reference state: counts as plain integers 0..999, scanner from cycles since reset.
    int   m_cw, m_cs, m_cyc;
    logic m_tcw, m_tcs, m_ovw, m_ovs;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_load(input logic [11:0] lv);
        int v = 0;
        int p = 1;
        for (int k = 0; k < N; k++) begin
            int d = int'(lv[k*4 +: 4]);
            if (d > 9) d = 9;
            v += d * p;
            p *= 10;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s txn=%0d actual=%0h required=%0h", name, txn, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic [11:0] lv,
                         input logic e, input logic u, input logic c);
        int   v;
        logic bw, bs;
        rst = r; load = l; load_val = lv; en = e; up = u; clr_ovf = c;
        if (r) begin
            m_cw = 0; m_cs = 0; m_tcw = 0; m_tcs = 0; m_ovw = 0; m_ovs = 0; m_cyc = 0;
        end else begin
            m_cyc++;
            if (l) begin
                v = clamp_load(lv);
                m_cw = v; m_cs = v; m_tcw = 0; m_tcs = 0;
                m_ovw = m_ovw & ~c; m_ovs = m_ovs & ~c;
            end else if (e) begin
                bw = u ? (m_cw == MAXV) : (m_cw == 0);
                bs = u ? (m_cs == MAXV) : (m_cs == 0);
                m_cw = u ? (m_cw + 1) % (MAXV + 1) : (m_cw + MAXV) % (MAXV + 1);
                if (!bs) m_cs = u ? m_cs + 1 : m_cs - 1;
                m_tcw = bw; m_tcs = bs;
                m_ovw = bw | (m_ovw & ~c);
                m_ovs = bs | (m_ovs & ~c);
            end else begin
                m_tcw = 0; m_tcs = 0;
                m_ovw = m_ovw & ~c; m_ovs = m_ovs & ~c;
            end
        end
        @(posedge clk);
        q.push_back('{cw: m_cw, tcw: m_tcw, ovw: m_ovw, cs: m_cs, tcs: m_tcs, ovs: m_ovs,
                      idx: (m_cyc / SCAN_DIV) % N});
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            int   pw;
            e  = q.pop_front();
            pw = (e.idx == 0) ? 1 : (e.idx == 1) ? 10 : 100;
            check("count_wrap", 32'(count_w), 32'(to_bcd(e.cw)));
            check("tc_wrap",    32'(tc_w),    32'(e.tcw));
            check("ovf_wrap",   32'(ovf_w),   32'(e.ovw));
            check("count_sat",  32'(count_s), 32'(to_bcd(e.cs)));
            check("tc_sat",     32'(tc_s),    32'(e.tcs));
            check("ovf_sat",    32'(ovf_s),   32'(e.ovs));
            check("seg_sel",    32'(seg_sel_w),   32'(1 << e.idx));
            check("seg_digit",  32'(seg_digit_w), 32'((e.cw / pw) % 10));
            $display("txn %0d count=%h/%h tc=%b/%b ovf=%b/%b sel=%b digit=%h",
                     txn, count_w, count_s, tc_w, tc_s, ovf_w, ovf_s, seg_sel_w, seg_digit_w);
            txn++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached txn=%0d", txn);
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic        r, l, e, u, c;
        logic [11:0] lv;
        int          sel;

        // Reset for two cycles, then idle long enough to see the first scan advance.
        repeat (2) drive(1, 0, 12'h000, 0, 0, 0);
        repeat (4) drive(0, 0, 12'h000, 0, 0, 0);

        // Ripple carry through two digits and back.
        drive(0, 1, 12'h099, 0, 0, 0);
        drive(0, 0, 12'h000, 1, 1, 0);
        drive(0, 0, 12'h000, 1, 0, 0);

        // Wrap at all-9s, then clear the sticky flag.
        drive(0, 1, 12'h998, 0, 0, 0);
        repeat (2) drive(0, 0, 12'h000, 1, 1, 0);
        drive(0, 0, 12'h000, 0, 0, 1);

        // Down through zero: wrapping instance rolls to 999, saturating one holds with tc.
        drive(0, 1, 12'h001, 0, 0, 0);
        repeat (3) drive(0, 0, 12'h000, 1, 0, 0);

        // Load beats enable, and illegal nibbles clamp to 9.
        drive(0, 1, 12'hA5F, 1, 1, 0);

        // Boundary step with a coincident clear: the set wins.
        drive(0, 1, 12'h999, 0, 0, 1);
        drive(0, 0, 12'h000, 1, 1, 1);
        repeat (2) drive(0, 0, 12'h000, 1, 1, 0);

        // Reset in the middle of counting and scanning.
        drive(1, 0, 12'h000, 1, 1, 0);
        repeat (3) drive(0, 0, 12'h000, 1, 1, 0);

        for (int i = 0; i < 500; i++) begin
            r   = ($urandom_range(0, 59) == 0);
            l   = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 3);
            lv  = (sel == 0) ? 12'h999 : (sel == 1) ? 12'h000 : 12'($urandom);
            e   = ($urandom_range(0, 3) != 0);
            u   = 1'($urandom_range(0, 1));
            c   = ($urandom_range(0, 9) == 0);
            drive(r, l, lv, e, u, c);
        end

        drive(0, 0, 12'h000, 0, 0, 0);
        repeat (2) @(posedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
